// File: rtl/dart_word_tx.sv
// dart_word_tx: pops words from a show-ahead FIFO and sends them as UART bytes.
// Frames are 8N1. Define DWT_PARITY_EN for 8E1 frames (even parity bit after the data).
// Line and busy are registered. tx_ack is a combinational pop strobe taken in IDLE.
module dart_word_tx #(
    parameter int WIDTH          = 16,
    parameter int CLKS_PER_BIT   = 434,
    parameter int LOW_BYTE_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ack,
    output logic             busy,
    output logic             RS232_TX_DATA
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef DWT_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_word, w_word_nxt;
    logic             r_line, w_line_nxt;
    logic             r_busy;
    logic             w_ack;
    logic             w_tc;
    logic [7:0]       w_byte;

    // Byte idx of the word in transmit order.
    function automatic logic [7:0] pick_byte(input logic [WIDTH-1:0] word,
                                             input logic [IW-1:0]    idx);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == IW'(k)) begin
                if (LOW_BYTE_FIRST != 0) b = word[8*k +: 8];
                else                     b = word[8*(NBYTES-1-k) +: 8];
            end
        end
        return b;
    endfunction

    assign w_tc = (r_cnt == CW'(CLKS_PER_BIT - 1));

    // Next-state logic: bit timer, bit/byte indices, word capture and pop strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_word_nxt  = r_word;
        w_ack       = 1'b0;
        if (r_state != S_IDLE) w_cnt_nxt = w_tc ? '0 : r_cnt + CW'(1);
        case (r_state)
            S_IDLE: begin
                if (enable && tx_valid) begin
                    w_ack       = 1'b1;
                    w_word_nxt  = tx_data;
                    w_idx_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tc) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    if (r_bit == 3'd7) begin
`ifdef DWT_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
`ifdef DWT_PARITY_EN
            S_PARITY: begin
                if (w_tc) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tc) begin
                    if (r_idx != IW'(NBYTES - 1)) begin
                        w_idx_nxt   = r_idx + IW'(1);
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line level for the coming cycle, derived from the next state so the registered
    // output changes exactly on bit-timer boundaries.
    always_comb begin
        w_byte = pick_byte(w_word_nxt, w_idx_nxt);
        case (w_state_nxt)
            S_START:  w_line_nxt = 1'b0;
            S_DATA:   w_line_nxt = w_byte[w_bit_nxt];
`ifdef DWT_PARITY_EN
            S_PARITY: w_line_nxt = ^w_byte;
`endif
            default:  w_line_nxt = 1'b1;
        endcase
    end

    // State and output registers; reset truncates any frame in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_idx   <= w_idx_nxt;
            r_word  <= w_word_nxt;
            r_line  <= w_line_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Pop strobe is suppressed while reset is held so no word is lost to reset.
    assign tx_ack        = w_ack & reset;
    assign busy          = r_busy;
    assign RS232_TX_DATA = r_line;

endmodule
